// File: rtl/pll_pkg.sv
//------------------------------------------------------------------------------
// pll_pkg : shared widths, clamp limits and dither LFSR constants for the DCO.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pll_pkg;

    localparam int ACC_W = 24;
    localparam int DAC_W = 20;
    localparam int DIV_W = 8;

    localparam logic [DAC_W-1:0] DAC_MID = {1'b1, {(DAC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] FCW_MIN = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] FCW_MAX = {1'b0, {(ACC_W-1){1'b1}}};

    // x^16 + x^14 + x^13 + x^11 + 1 as right-shifting Fibonacci taps (bits 0,2,3,5)
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fb_divider.sv
//------------------------------------------------------------------------------
// fb_divider : divide-by-N of the DCO edge tick; N reloads only at terminal count.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fb_divider #(
    parameter int DIV_W   = 8,
    parameter int DIV_RST = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             tick,
    input  logic [DIV_W-1:0] div_n,
    output logic             fdiv
);
    import pll_pkg::*;

    localparam logic [DIV_W-1:0] N_RST = (DIV_RST < 2) ? DIV_W'(2) : DIV_W'(DIV_RST);

    function automatic logic [DIV_W-1:0] at_least_two(input logic [DIV_W-1:0] n);
        return (n < DIV_W'(2)) ? DIV_W'(2) : n;
    endfunction

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] n_q;
    logic [DIV_W-1:0] n_d;
    logic             fdiv_q;
    logic             fdiv_d;

    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        n_d   = n_q;
        if (cnt_q == n_q - DIV_W'(1)) begin
            cnt_d = '0;
            n_d   = at_least_two(div_n);
        end
        // High for counts 0..floor(N/2)-1, so odd N gets the shorter high phase
        fdiv_d = (cnt_d < (n_d >> 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= N_RST - DIV_W'(1);
            n_q    <= N_RST;
            fdiv_q <= 1'b0;
        end else if (enable && tick) begin
            cnt_q  <= cnt_d;
            n_q    <= n_d;
            fdiv_q <= fdiv_d;
        end
    end

    assign fdiv = fdiv_q;

endmodule

`default_nettype wire

// File: rtl/dco_fdiv_gen.sv
//------------------------------------------------------------------------------
// dco_fdiv_gen : phase-accumulator DCO steered by the loop-filter word, feeding
// the feedback divider. Define DCO_DITHER_EN to add LFSR LSB dither to the step.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dco_fdiv_gen #(
    parameter int               ACC_W      = 24,
    parameter int               DAC_W      = 20,
    parameter logic [ACC_W-1:0] BASE_FCW   = 24'h100000,
    parameter int               GAIN_SHIFT = 4,
    parameter int               DIV_W      = 8,
    parameter int               DIV_RST    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DAC_W-1:0] dac,
    input  logic [DIV_W-1:0] div_n,
    output logic [ACC_W-1:0] fcw_out,
    output logic             dco_out,
    output logic             fdiv
);
    import pll_pkg::*;

    // Two guard bits keep base + offset from overflowing before the clamp
    localparam int               SUM_W  = ACC_W + 2;
    localparam logic [ACC_W-1:0] FCW_LO = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] FCW_HI = {1'b0, {(ACC_W-1){1'b1}}};

    logic signed [DAC_W-1:0] offset_raw;
    logic signed [DAC_W-1:0] offset_gain;
    logic        [SUM_W-1:0] offset_ext;
    logic        [SUM_W-1:0] fcw_sum;
    logic        [ACC_W-1:0] fcw_d;
    logic        [ACC_W-1:0] fcw_q;
    logic        [ACC_W-1:0] acc_d;
    logic        [ACC_W-1:0] acc_q;
    logic                    dco_q;
    logic                    dco_rise;

    assign offset_raw  = $signed({~dac[DAC_W-1], dac[DAC_W-2:0]});
    assign offset_gain = offset_raw >>> GAIN_SHIFT;
    assign offset_ext  = {{(SUM_W-DAC_W){offset_gain[DAC_W-1]}}, offset_gain};
    assign fcw_sum     = {2'b00, BASE_FCW} + offset_ext;

    // Cap below half scale so each accumulator wrap yields exactly one MSB edge
    always_comb begin
        fcw_d = fcw_sum[ACC_W-1:0];
        if (fcw_sum[SUM_W-1] || (fcw_sum == '0)) begin
            fcw_d = FCW_LO;
        end else if (fcw_sum[SUM_W-2:ACC_W-1] != '0) begin
            fcw_d = FCW_HI;
        end
    end

`ifdef DCO_DITHER_EN
    logic [LFSR_W-1:0] lfsr_q;

    assign acc_d = acc_q + fcw_q + {{(ACC_W-1){1'b0}}, lfsr_q[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else if (enable) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end
`else
    assign acc_d = acc_q + fcw_q;
`endif

    assign dco_rise = enable & ~dco_q & acc_d[ACC_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            fcw_q <= BASE_FCW;
            dco_q <= 1'b0;
        end else if (enable) begin
            acc_q <= acc_d;
            fcw_q <= fcw_d;
            dco_q <= acc_d[ACC_W-1];
        end
    end

    fb_divider #(
        .DIV_W   (DIV_W),
        .DIV_RST (DIV_RST)
    ) u_fb_divider (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (dco_rise),
        .div_n  (div_n),
        .fdiv   (fdiv)
    );

    assign fcw_out = fcw_q;
    assign dco_out = dco_q;

endmodule

`default_nettype wire

// File: tb/tb_dco_fdiv_gen.sv
//------------------------------------------------------------------------------
// tb_dco_fdiv_gen : directed stimulus; expected fdiv edges (level, enabled clocks
// since the previous edge) are queued and checked by an independent monitor.
//------------------------------------------------------------------------------
`default_nettype none

module tb_dco_fdiv_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [19:0] dac = 20'h80000;
    logic [7:0]  div_n = 8'd4;
    logic [23:0] fcw_out;
    logic        dco_out;
    logic        fdiv;

    logic [19:0] dac_lo = 20'h00000;
    logic [19:0] dac_hi = 20'hFFFFF;
    logic [23:0] fcw_lo, fcw_hi;
    logic        dco_lo, dco_hi, fdiv_lo, fdiv_hi;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic lvl;
        int   dur;
    } ev_t;

    ev_t  exp_q[$];
    logic sb_armed = 1'b0;
    int   en_cnt = 0;
    logic prev_fdiv = 1'b0;

    dco_fdiv_gen u_dut (
        .clk(clk), .rst(rst), .enable(enable), .dac(dac), .div_n(div_n),
        .fcw_out(fcw_out), .dco_out(dco_out), .fdiv(fdiv)
    );

    dco_fdiv_gen #(.BASE_FCW(24'h040000), .GAIN_SHIFT(0)) u_lo (
        .clk(clk), .rst(rst), .enable(enable), .dac(dac_lo), .div_n(div_n),
        .fcw_out(fcw_lo), .dco_out(dco_lo), .fdiv(fdiv_lo)
    );

    dco_fdiv_gen #(.BASE_FCW(24'h7F0000), .GAIN_SHIFT(0)) u_hi (
        .clk(clk), .rst(rst), .enable(enable), .dac(dac_hi), .div_n(div_n),
        .fcw_out(fcw_hi), .dco_out(dco_hi), .fdiv(fdiv_hi)
    );

    always #5 clk = ~clk;

    // Monitor: every fdiv transition is matched against the head of the queue
    always @(negedge clk) begin
        if (rst) begin
            en_cnt    = 0;
            prev_fdiv = fdiv;
        end else begin
            if (enable) en_cnt++;
            if (fdiv !== prev_fdiv) begin
                if (sb_armed) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL fdiv_edge: unexpected level=%0b after %0d clk, no edge required",
                                 fdiv, en_cnt);
                    end else begin
                        ev_t e;
                        e = exp_q.pop_front();
                        if (e.lvl !== fdiv || e.dur != en_cnt) begin
                            failures++;
                            $display("FAIL fdiv_edge: got level=%0b after %0d clk, required level=%0b after %0d clk",
                                     fdiv, en_cnt, e.lvl, e.dur);
                        end
                    end
                end
                prev_fdiv = fdiv;
                en_cnt    = 0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_ev(input logic lvl, input int dur);
        ev_t e;
        e.lvl = lvl;
        e.dur = dur;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    task automatic wait_sb(input int maxc, input string nm);
        int c = 0;
        while (exp_q.size() != 0 && c < maxc) begin
            step();
            c++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: timeout with %0d fdiv edges pending, required 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int c;
        int rises, first, last;
        logic pd;
`ifdef DCO_DITHER_EN
        logic [15:0] lf;
`endif

        // Reset state
        steps(2);
        chk("rst_fcw", fcw_out, 32'h100000);
        chk("rst_dco", dco_out, 0);
        chk("rst_fdiv", fdiv, 0);
        chk("rst_fcw_lo", fcw_lo, 32'h040000);
        chk("rst_fcw_hi", fcw_hi, 32'h7F0000);

        // Nominal run: DCO clk/16, N=4 -> fdiv 32 high / 32 low, first rise at DCO edge 1
        rst = 1'b0; enable = 1'b1; dac = 20'h80000; div_n = 8'd4;
        sb_armed = 1'b1;
        push_ev(1, 8); push_ev(0, 32); push_ev(1, 32); push_ev(0, 32); push_ev(1, 32);
        step();
        chk("clamp_low_fcw", fcw_lo, 32'h000001);
        chk("clamp_high_fcw", fcw_hi, 32'h7FFFFF);

        c = 0;
        while (dco_out !== 1'b1 && c < 40) begin step(); c++; end
        chk("dco_first_rise_clk", c + 1, 8);
        c = 0;
        while (dco_out === 1'b1 && c < 40) begin step(); c++; end
        chk("dco_high_clk", c, 8);
        c = 0;
        while (dco_out === 1'b0 && c < 40) begin step(); c++; end
        chk("dco_low_clk", c, 8);
        wait_sb(400, "sb_nominal");

        // div_n 4->6 while div_cnt=1: current period still ends at 4 edges
        steps(20);
        div_n = 8'd6;
        push_ev(0, 32); push_ev(1, 32); push_ev(0, 48); push_ev(1, 48);
        wait_sb(300, "sb_div6");

        // div_n=1 applies at the end of the running 6-edge period, then N=2
        div_n = 8'd1;
        push_ev(0, 48); push_ev(1, 48); push_ev(0, 16); push_ev(1, 16);
        push_ev(0, 16); push_ev(1, 16);
        wait_sb(400, "sb_div1");

        // Freeze 10 cycles mid-period; dac change while frozen must not load
        steps(5);
        enable = 1'b0; dac = 20'hFFFFF;
        push_ev(0, 16); push_ev(1, 16);
        steps(10);
        chk("hold_dco", dco_out, 1);
        chk("hold_fdiv", fdiv, 1);
        chk("hold_fcw", fcw_out, 32'h100000);
        dac = 20'h80000; enable = 1'b1;
        wait_sb(200, "sb_resume");

        // dac extremes reach fcw_out one cycle later
        sb_armed = 1'b0;
        dac = 20'hFFFFF; step();
        chk("fcw_dac_max", fcw_out, 32'h107FFF);
        dac = 20'h00000; step();
        chk("fcw_dac_min", fcw_out, 32'h0F8000);
        dac = 20'h80000; step();
        chk("fcw_dac_mid", fcw_out, 32'h100000);

        // Reset pulse while fdiv is high
        c = 0;
        while (fdiv !== 1'b1 && c < 100) begin step(); c++; end
        chk("fdiv_high_before_rst", fdiv, 1);
        rst = 1'b1; dac = 20'hFFFFF;
        step();
        chk("rstpulse_fdiv", fdiv, 0);
        chk("rstpulse_dco", dco_out, 0);
        chk("rstpulse_fcw", fcw_out, 32'h100000);
        rst = 1'b0; dac = 20'h80000;
        push_ev(1, 8); push_ev(0, 16); push_ev(1, 16);
        sb_armed = 1'b1;
        wait_sb(200, "sb_after_rst");

        // Long-run DCO period
        sb_armed = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        rises = 0; first = 0; last = 0; pd = dco_out;
`ifdef DCO_DITHER_EN
        lf = 16'hACE1;
`endif
        for (int i = 1; i <= 1600; i++) begin
            step();
            if (dco_out === 1'b1 && pd === 1'b0) begin
                if (rises == 0) first = i;
                last = i;
                rises++;
            end
            pd = dco_out;
`ifdef DCO_DITHER_EN
            lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
            if (i <= 32) chk("lfsr_seq", u_dut.lfsr_q, lf);
`endif
        end
        chk("dco_rise_count", rises, 100);
`ifdef DCO_DITHER_EN
        checks++;
        if (rises < 2 || 10 * (last - first) < 159 * (rises - 1) || 10 * (last - first) > 160 * (rises - 1)) begin
            failures++;
            $display("FAIL dco_mean_period: span=%0d over %0d periods, required mean in [15.9,16.0]",
                     last - first, rises - 1);
        end
`else
        chk("dco_mean_period_span", last - first, 16 * 99);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
